// File: rtl/conv_pkg.sv
// Shared types and constant helpers for the convolution feeder controller.
package conv_pkg;

    localparam int COORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Sideband travelling alongside each pixel: row/col hold output-map coordinates.
    typedef struct packed {
        logic               valid;
        logic               win;
        logic [COORD_W-1:0] row;
        logic [COORD_W-1:0] col;
    } tag_t;

    // Bits needed to count 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int out_count(input int w, input int h, input int k, input int s);
        return ((h - k) / s + 1) * ((w - k) / s + 1);
    endfunction

endpackage

// File: rtl/conv_tag_pipe.sv
// Shift register of pixel tags with a common advance enable and synchronous clear.
module conv_tag_pipe
    import conv_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter bit KEEP_COORD = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             adv_i,
    input  tag_t             tag_i,
    output logic [DEPTH-1:0] valid_o,
    output tag_t             tag_o
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            tag_t src;
            tag_t stage_q;

            if (gi == 0) begin : g_head
                assign src = tag_i;
            end else begin : g_link
                assign src = g_stage[gi-1].stage_q;
            end

            always_ff @(posedge clk) begin
                if (rst || clr_i) begin
                    stage_q <= '0;
                end else if (adv_i) begin
                    stage_q <= src;
                    // Without coordinate output the last stage keeps only valid/win.
                    if (gi == DEPTH - 1 && !KEEP_COORD) begin
                        stage_q.row <= '0;
                        stage_q.col <= '0;
                    end
                end
            end

            assign valid_o[gi] = stage_q.valid;
        end
    endgenerate

    assign tag_o = g_stage[DEPTH-1].stage_q;

endmodule

// File: rtl/conv_feed_ctrl.sv
// Raster feeder for the line-buffer convolutor with window tagging and output backpressure.
// Define CONV_FEED_COORD_EN to expose out_row_o/out_col_o output-map coordinates.
module conv_feed_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_W        = 100,
    parameter int IMG_H        = 100,
    parameter int DATA_WIDTH   = 16,
    parameter int K_SIZE       = 3,
    parameter int STRIDE       = 1,
    parameter int ADDR_WIDTH   = 14,
    parameter int RD_LATENCY   = 1,
    parameter int CONV_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  conv_en_o,
    output logic [DATA_WIDTH-1:0] conv_data_o,
    input  logic [DATA_WIDTH-1:0] conv_result_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
`ifdef CONV_FEED_COORD_EN
    output logic [15:0]           out_row_o,
    output logic [15:0]           out_col_o,
`endif
    input  logic                  out_ready_i
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int DEPTH = RD_LATENCY + CONV_LATENCY;
    localparam int CW    = cnt_width((IMG_W > IMG_H) ? IMG_W : IMG_H);
    localparam int PW    = cnt_width(STRIDE);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
    localparam logic [CW-1:0]         COL_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0]         ROW_LAST  = CW'(IMG_H - 1);
    localparam logic [CW-1:0]         WIN_FIRST = CW'(K_SIZE - 1);
    localparam logic [PW-1:0]         PH_LAST   = PW'(STRIDE - 1);

`ifdef CONV_FEED_COORD_EN
    localparam bit KEEP_COORD = 1'b1;
`else
    localparam bit KEEP_COORD = 1'b0;
`endif

    state_e state_q;
    logic   busy_q;
    logic   done_q;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         col_q, col_d;
    logic [CW-1:0]         row_q, row_d;
    logic [PW-1:0]         cph_q, cph_d;
    logic [PW-1:0]         rph_q, rph_d;
    logic [COORD_W-1:0]    ocol_q, ocol_d;
    logic [COORD_W-1:0]    orow_q, orow_d;

    logic             adv;
    logic             issue;
    logic             accept;
    logic             win;
    tag_t             tag_in;
    tag_t             tail;
    logic [DEPTH-1:0] pipe_valid;

    // A pending beat that the consumer refuses freezes the whole block.
    assign adv    = !(out_valid_o && !out_ready_i);
    assign issue  = (state_q == ST_FEED) && adv;
    assign accept = (state_q == ST_IDLE) && start_i;

    // Phase counters are zero exactly on stride-aligned window positions.
    assign win = (row_q >= WIN_FIRST) && (col_q >= WIN_FIRST) &&
                 (rph_q == '0) && (cph_q == '0);

    always_comb begin
        tag_in       = '0;
        tag_in.valid = issue;
        tag_in.win   = win;
        tag_in.row   = orow_q;
        tag_in.col   = ocol_q;
    end

    always_comb begin
        addr_d = addr_q;
        col_d  = col_q;
        row_d  = row_q;
        cph_d  = cph_q;
        rph_d  = rph_q;
        ocol_d = ocol_q;
        orow_d = orow_q;
        if (accept) begin
            addr_d = '0;
            col_d  = '0;
            row_d  = '0;
            cph_d  = '0;
            rph_d  = '0;
            ocol_d = '0;
            orow_d = '0;
        end else if (issue) begin
            addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
            if (col_q == COL_LAST) begin
                col_d  = '0;
                cph_d  = '0;
                ocol_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d  = '0;
                    rph_d  = '0;
                    orow_d = '0;
                end else begin
                    row_d = row_q + CW'(1);
                    if (row_q >= WIN_FIRST) begin
                        if (rph_q == PH_LAST) begin
                            rph_d  = '0;
                            orow_d = orow_q + 16'd1;
                        end else begin
                            rph_d = rph_q + PW'(1);
                        end
                    end
                end
            end else begin
                col_d = col_q + CW'(1);
                if (col_q >= WIN_FIRST) begin
                    if (cph_q == PH_LAST) begin
                        cph_d  = '0;
                        ocol_d = ocol_q + 16'd1;
                    end else begin
                        cph_d = cph_q + PW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
            cph_q  <= '0;
            rph_q  <= '0;
            ocol_q <= '0;
            orow_q <= '0;
        end else begin
            addr_q <= addr_d;
            col_q  <= col_d;
            row_q  <= row_d;
            cph_q  <= cph_d;
            rph_q  <= rph_d;
            ocol_q <= ocol_d;
            orow_q <= orow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_FEED;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FEED: begin
                    if (adv && addr_q == LAST_ADDR) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_valid == '0) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    conv_tag_pipe #(
        .DEPTH      (DEPTH),
        .KEEP_COORD (KEEP_COORD)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (accept),
        .adv_i   (adv),
        .tag_i   (tag_in),
        .valid_o (pipe_valid),
        .tag_o   (tail)
    );

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign mem_en_o    = issue;
    assign mem_addr_o  = addr_q;
    assign conv_data_o = mem_data_i;
    assign conv_en_o   = pipe_valid[RD_LATENCY-1] && adv;
    assign out_data_o  = conv_result_i;
    assign out_valid_o = tail.valid && tail.win;

`ifdef CONV_FEED_COORD_EN
    assign out_row_o = tail.row;
    assign out_col_o = tail.col;
`else
    logic unused_coord;
    assign unused_coord = ^{tail.row, tail.col};
`endif

endmodule
